cop_mem_txn_seq: RTL and testbench

- Sequences up to four memory transactions per coprocessor instruction (gather/scatter and multi-word load/store) over the coprocessor's single memory port.
- Sits between the ISE execute stage and the memory interface.
- Collects read data and error status per lane, then returns a single response to the pipeline.
- Lane numbering 0-3 matches the per-transaction numbering used by the formal vtx_mem_*_N trace.

---
 rtl/cop_mem_txn_seq_if.sv | 67 ++++++
 rtl/cop_mem_txn_seq.sv | 215 +++++++++++++++++++++
 tb/tb_cop_mem_txn_seq.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop_mem_txn_seq_if.sv
// Request, memory-port and response signals of the coprocessor memory sequencer.
// With COP_MEM_TRACE_EN defined, the per-lane trace record is carried here as well.
interface cop_mem_txn_seq_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_wen;
    logic [1:0]   req_count;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_ben;
    logic         flush;

    logic         mem_cen;
    logic         mem_wen;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_ben;
    logic         mem_stall;
    logic [31:0]  mem_rdata;
    logic         mem_error;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_rdata;
    logic         rsp_error;
    logic         rsp_misalign;
    logic [1:0]   rsp_err_idx;

`ifdef COP_MEM_TRACE_EN
    logic [3:0]   trc_cen;
    logic [3:0]   trc_wen;
    logic [127:0] trc_addr;
    logic [127:0] trc_wdata;
    logic [127:0] trc_rdata;
    logic [15:0]  trc_ben;
    logic [3:0]   trc_error;

    // master is the execute stage plus memory; slave is the sequencer
    modport master (
        output req_valid, req_wen, req_count, req_addr, req_wdata, req_ben, flush,
        output mem_stall, mem_rdata, mem_error, rsp_ready,
        input  req_ready, mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_misalign, rsp_err_idx,
        input  trc_cen, trc_wen, trc_addr, trc_wdata, trc_rdata, trc_ben, trc_error
    );
    modport slave (
        input  req_valid, req_wen, req_count, req_addr, req_wdata, req_ben, flush,
        input  mem_stall, mem_rdata, mem_error, rsp_ready,
        output req_ready, mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben,
        output rsp_valid, rsp_rdata, rsp_error, rsp_misalign, rsp_err_idx,
        output trc_cen, trc_wen, trc_addr, trc_wdata, trc_rdata, trc_ben, trc_error
    );
`else
    modport master (
        output req_valid, req_wen, req_count, req_addr, req_wdata, req_ben, flush,
        output mem_stall, mem_rdata, mem_error, rsp_ready,
        input  req_ready, mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_misalign, rsp_err_idx
    );
    modport slave (
        input  req_valid, req_wen, req_count, req_addr, req_wdata, req_ben, flush,
        input  mem_stall, mem_rdata, mem_error, rsp_ready,
        output req_ready, mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben,
        output rsp_valid, rsp_rdata, rsp_error, rsp_misalign, rsp_err_idx
    );
`endif
endinterface

// File: rtl/cop_mem_txn_seq.sv
// Sequences up to four in-order memory transactions per coprocessor request over one port.
// Optional per-lane bus trace record enabled by defining COP_MEM_TRACE_EN.
module cop_mem_txn_seq (
    input  logic                g_clk,
    input  logic                g_resetn,
    cop_mem_txn_seq_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, RESP, DONE} state_t;

    state_t       state;
    logic         wen_q;
    logic [1:0]   count_q;
    logic [127:0] addr_q;
    logic [127:0] wdata_q;
    logic [15:0]  ben_q;
    logic [1:0]   idx;
    logic         abort;

    logic         req_ready_q;
    logic         mem_cen_q;
    logic         mem_wen_q;
    logic [31:0]  mem_addr_q;
    logic [31:0]  mem_wdata_q;
    logic [3:0]   mem_ben_q;
    logic         rsp_valid_q;
    logic [127:0] rsp_rdata_q;
    logic         rsp_error_q;
    logic         rsp_misalign_q;
    logic [1:0]   rsp_err_idx_q;

    logic [6:0]   lane_off;
    logic [3:0]   ben_off;
    logic [31:0]  lane_addr;

    assign lane_off  = {idx, 5'd0};
    assign ben_off   = {idx, 2'd0};
    assign lane_addr = addr_q[lane_off +: 32];

`ifdef COP_MEM_TRACE_EN
    logic [3:0]   trc_cen_q;
    logic [3:0]   trc_wen_q;
    logic [127:0] trc_addr_q;
    logic [127:0] trc_wdata_q;
    logic [127:0] trc_rdata_q;
    logic [15:0]  trc_ben_q;
    logic [3:0]   trc_error_q;

    assign bus.trc_cen   = trc_cen_q;
    assign bus.trc_wen   = trc_wen_q;
    assign bus.trc_addr  = trc_addr_q;
    assign bus.trc_wdata = trc_wdata_q;
    assign bus.trc_rdata = trc_rdata_q;
    assign bus.trc_ben   = trc_ben_q;
    assign bus.trc_error = trc_error_q;
`endif

    assign bus.req_ready    = req_ready_q;
    assign bus.mem_cen      = mem_cen_q;
    assign bus.mem_wen      = mem_wen_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_ben      = mem_ben_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.rsp_misalign = rsp_misalign_q;
    assign bus.rsp_err_idx  = rsp_err_idx_q;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state          <= IDLE;
            wen_q          <= 1'b0;
            count_q        <= 2'd0;
            addr_q         <= '0;
            wdata_q        <= '0;
            ben_q          <= '0;
            idx            <= 2'd0;
            abort          <= 1'b0;
            req_ready_q    <= 1'b1;
            mem_cen_q      <= 1'b0;
            mem_wen_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_ben_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_error_q    <= 1'b0;
            rsp_misalign_q <= 1'b0;
            rsp_err_idx_q  <= 2'd0;
`ifdef COP_MEM_TRACE_EN
            trc_cen_q      <= '0;
            trc_wen_q      <= '0;
            trc_addr_q     <= '0;
            trc_wdata_q    <= '0;
            trc_rdata_q    <= '0;
            trc_ben_q      <= '0;
            trc_error_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wen_q          <= bus.req_wen;
                        count_q        <= bus.req_count;
                        addr_q         <= bus.req_addr;
                        wdata_q        <= bus.req_wdata;
                        ben_q          <= bus.req_ben;
                        idx            <= 2'd0;
                        abort          <= 1'b0;
                        req_ready_q    <= 1'b0;
                        rsp_rdata_q    <= '0;
                        rsp_error_q    <= 1'b0;
                        rsp_misalign_q <= 1'b0;
                        rsp_err_idx_q  <= 2'd0;
                        state          <= CHECK;
`ifdef COP_MEM_TRACE_EN
                        trc_cen_q      <= '0;
                        trc_wen_q      <= '0;
                        trc_addr_q     <= '0;
                        trc_wdata_q    <= '0;
                        trc_rdata_q    <= '0;
                        trc_ben_q      <= '0;
                        trc_error_q    <= '0;
`endif
                    end
                end
                CHECK: begin
                    if (bus.flush) begin
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else if (lane_addr[1:0] != 2'b00) begin
                        rsp_error_q    <= 1'b1;
                        rsp_misalign_q <= 1'b1;
                        rsp_err_idx_q  <= idx;
                        rsp_valid_q    <= 1'b1;
                        state          <= DONE;
                    end else begin
                        mem_cen_q   <= 1'b1;
                        mem_wen_q   <= wen_q;
                        mem_addr_q  <= lane_addr;
                        mem_wdata_q <= wdata_q[lane_off +: 32];
                        mem_ben_q   <= ben_q[ben_off +: 4];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An accepted transaction always gets its response cycle, even when flushed
                    if (!bus.mem_stall) begin
                        mem_cen_q   <= 1'b0;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_ben_q   <= '0;
                        abort       <= bus.flush;
                        state       <= RESP;
`ifdef COP_MEM_TRACE_EN
                        trc_cen_q[idx]              <= 1'b1;
                        trc_wen_q[idx]              <= mem_wen_q;
                        trc_addr_q[lane_off +: 32]  <= mem_addr_q;
                        trc_wdata_q[lane_off +: 32] <= mem_wdata_q;
                        trc_ben_q[ben_off +: 4]     <= mem_ben_q;
`endif
                    end else if (bus.flush) begin
                        mem_cen_q   <= 1'b0;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_ben_q   <= '0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                RESP: begin
`ifdef COP_MEM_TRACE_EN
                    trc_error_q[idx]            <= bus.mem_error;
                    trc_rdata_q[lane_off +: 32] <= bus.mem_rdata;
`endif
                    if (bus.flush || abort) begin
                        abort       <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        if (!wen_q) begin
                            rsp_rdata_q[lane_off +: 32] <= bus.mem_rdata;
                        end
                        if (bus.mem_error) begin
                            rsp_error_q    <= 1'b1;
                            rsp_misalign_q <= 1'b0;
                            rsp_err_idx_q  <= idx;
                            rsp_valid_q    <= 1'b1;
                            state          <= DONE;
                        end else if (idx == count_q) begin
                            rsp_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= CHECK;
                        end
                    end
                end
                DONE: begin
                    if (bus.flush || bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cop_mem_txn_seq.sv
// Self-checking bench for cop_mem_txn_seq: directed scenarios plus randomized requests
// checked against a lane-by-lane reference model.
module tb_cop_mem_txn_seq;
    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    cop_mem_txn_seq_if bus();
    cop_mem_txn_seq dut (.g_clk(g_clk), .g_resetn(g_resetn), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic         r_wen;
    logic [1:0]   r_count;
    logic [127:0] r_addr, r_wdata, plan_rdata;
    logic [15:0]  r_ben;
    logic [3:0]   plan_err;
    int           plan_stall [4];

    logic [31:0]  exp_addr [$];
    logic [127:0] exp_rdata, exp_trc_rdata;
    logic         exp_error, exp_misalign;
    logic [1:0]   exp_idx;
    logic [3:0]   exp_trc_cen;
    int           exp_cycle, exp_cen_cycles;

    logic [31:0]  obs_addr [$];
    logic [31:0]  obs_wdata [$];
    logic [3:0]   obs_ben [$];
    logic         obs_wen [$];
    int           obs_cycle, obs_first_cen, obs_unstable, obs_cen_cycles;
    bit           obs_timeout;

    task automatic drive_idle();
        bus.req_valid = 0; bus.req_wen = 0; bus.req_count = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.req_ben = 0; bus.flush = 0;
        bus.mem_stall = 0; bus.mem_rdata = 0; bus.mem_error = 0; bus.rsp_ready = 0;
    endtask

    // Walk lanes in order: misaligned lane stops before any access, bus error stops after it
    function automatic void build_model();
        logic [31:0] a;
        exp_addr.delete();
        exp_rdata = '0; exp_trc_rdata = '0; exp_trc_cen = '0;
        exp_error = 0; exp_misalign = 0; exp_idx = 0;
        exp_cycle = 1; exp_cen_cycles = 0;
        for (int i = 0; i <= int'(r_count); i++) begin
            a = r_addr[i*32 +: 32];
            if (a[1:0] != 2'b00) begin
                exp_error = 1; exp_misalign = 1; exp_idx = 2'(i);
                exp_cycle += 1;
                break;
            end
            exp_addr.push_back(a);
            exp_cycle += 3 + plan_stall[i];
            exp_cen_cycles += 1 + plan_stall[i];
            exp_trc_cen[i] = 1'b1;
            exp_trc_rdata[i*32 +: 32] = plan_rdata[i*32 +: 32];
            if (!r_wen) exp_rdata[i*32 +: 32] = plan_rdata[i*32 +: 32];
            if (plan_err[i]) begin
                exp_error = 1; exp_idx = 2'(i);
                break;
            end
        end
    endfunction

    task automatic start_req();
        @(negedge g_clk);
        bus.req_valid = 1; bus.req_wen = r_wen; bus.req_count = r_count;
        bus.req_addr = r_addr; bus.req_wdata = r_wdata; bus.req_ben = r_ben;
        @(negedge g_clk);
        bus.req_valid = 0;
        bus.req_addr = {4{$urandom}};
    endtask

    // Drive one request and act as the memory until rsp_valid or a cycle budget runs out
    task automatic applyStimulus();
        int n, nacc, stall_left, lane;
        bit loaded, pend;
        logic [68:0] held;
        obs_addr.delete(); obs_wdata.delete(); obs_ben.delete(); obs_wen.delete();
        obs_cycle = -1; obs_first_cen = -1; obs_unstable = 0; obs_cen_cycles = 0;
        obs_timeout = 0;
        nacc = 0; stall_left = 0; loaded = 0; pend = 0; lane = 0; held = '0;
        start_req();
        n = 1;
        while (n < 200) begin
            if (pend) begin
                bus.mem_rdata = plan_rdata[lane*32 +: 32];
                bus.mem_error = plan_err[lane];
                pend = 0;
            end else begin
                bus.mem_rdata = $urandom;
                bus.mem_error = 0;
            end
            if (bus.rsp_valid) begin
                obs_cycle = n;
                break;
            end
            if (bus.mem_cen) begin
                obs_cen_cycles++;
                if (obs_first_cen < 0) obs_first_cen = n;
                if (!loaded) begin
                    stall_left = (nacc < 4) ? plan_stall[nacc] : 0;
                    loaded = 1;
                    held = {bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_ben};
                end else if (held !== {bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_ben}) begin
                    obs_unstable++;
                end
                if (stall_left > 0) begin
                    bus.mem_stall = 1;
                    stall_left--;
                end else begin
                    bus.mem_stall = 0;
                    obs_addr.push_back(bus.mem_addr);
                    obs_wdata.push_back(bus.mem_wdata);
                    obs_ben.push_back(bus.mem_ben);
                    obs_wen.push_back(bus.mem_wen);
                    pend = 1; lane = nacc & 3; nacc++; loaded = 0;
                end
            end else begin
                bus.mem_stall = 1'($urandom_range(0, 1));
            end
            @(negedge g_clk);
            n++;
        end
        bus.mem_stall = 0; bus.mem_error = 0;
        if (obs_cycle < 0) obs_timeout = 1;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1;
        @(negedge g_clk);
        bus.rsp_ready = 0;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) plan_stall[i] = 0;
        plan_err = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        g_resetn = 0;
        repeat (3) @(negedge g_clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready);
        end
        vectors++;
        if ({bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_ben} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_mem: got cen=%b addr=%h expected all 0", bus.mem_cen, bus.mem_addr);
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_misalign, bus.rsp_err_idx} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_rsp: got valid=%b rdata=%h expected all 0", bus.rsp_valid, bus.rsp_rdata);
        end
        g_resetn = 1;
        @(negedge g_clk);
    endtask

    task automatic test_load4();
        clear_plan();
        r_wen = 0; r_count = 3; r_ben = 16'hFFFF; r_wdata = {4{$urandom}};
        r_addr = {32'h10C, 32'h108, 32'h104, 32'h100};
        plan_rdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        build_model();
        applyStimulus();
        vectors++;
        if (obs_timeout || obs_cycle !== 13) begin
            miscompares++; $display("[TB] FAIL load4_latency: got %0d expected 13", obs_cycle);
        end
        vectors++;
        if (obs_first_cen !== 2) begin
            miscompares++; $display("[TB] FAIL load4_first_cen: got %0d expected 2", obs_first_cen);
        end
        vectors++;
        if (obs_addr.size() !== 4 || obs_cen_cycles !== 4) begin
            miscompares++; $display("[TB] FAIL load4_pulses: got %0d accepts %0d cen cycles expected 4/4", obs_addr.size(), obs_cen_cycles);
        end
        for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
            vectors++;
            if (obs_addr[k] !== exp_addr[k]) begin
                miscompares++; $display("[TB] FAIL load4_order[%0d]: got %h expected %h", k, obs_addr[k], exp_addr[k]);
            end
        end
        vectors++;
        if (bus.rsp_rdata !== 128'h000000A3_000000A2_000000A1_000000A0 || bus.rsp_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL load4_rsp: got %h err=%b expected A3..A0 err=0", bus.rsp_rdata, bus.rsp_error);
        end
`ifdef COP_MEM_TRACE_EN
        vectors++;
        if (bus.trc_cen !== 4'hF || bus.trc_rdata !== plan_rdata || bus.trc_addr !== r_addr) begin
            miscompares++; $display("[TB] FAIL load4_trace: got cen=%h rdata=%h expected F/%h", bus.trc_cen, bus.trc_rdata, plan_rdata);
        end
`endif
        finish_rsp();
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL load4_release: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_store_stall();
        clear_plan();
        plan_stall[0] = 3;
        r_wen = 1; r_count = 1; r_ben = {12'h000, 4'h3, 4'hF}; r_wdata = {4{$urandom}};
        r_addr = {64'h0, 32'h404, 32'h400};
        plan_rdata = {4{$urandom}};
        build_model();
        applyStimulus();
        vectors++;
        if (obs_timeout || obs_cycle !== exp_cycle) begin
            miscompares++; $display("[TB] FAIL store_latency: got %0d expected %0d", obs_cycle, exp_cycle);
        end
        vectors++;
        if (obs_unstable !== 0 || obs_cen_cycles !== 5) begin
            miscompares++; $display("[TB] FAIL store_stable: got %0d changes %0d cen cycles expected 0/5", obs_unstable, obs_cen_cycles);
        end
        vectors++;
        if (obs_addr.size() !== 2) begin
            miscompares++; $display("[TB] FAIL store_count: got %0d expected 2", obs_addr.size());
        end else begin
            vectors++;
            if (obs_wdata[0] !== r_wdata[31:0] || obs_wdata[1] !== r_wdata[63:32] ||
                obs_ben[0] !== 4'hF || obs_ben[1] !== 4'h3 || obs_wen[0] !== 1'b1 || obs_wen[1] !== 1'b1 ||
                obs_addr[1] !== 32'h404) begin
                miscompares++; $display("[TB] FAIL store_lanes: got %h/%h ben %h/%h expected %h/%h ben F/3",
                                        obs_wdata[0], obs_wdata[1], obs_ben[0], obs_ben[1], r_wdata[31:0], r_wdata[63:32]);
            end
        end
        vectors++;
        if (bus.rsp_rdata !== '0 || bus.rsp_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL store_rdata: got %h expected 0", bus.rsp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_bus_error();
        clear_plan();
        plan_err = 4'b0010;
        r_wen = 0; r_count = 2; r_ben = 16'hFFFF; r_wdata = 0;
        r_addr = {32'h0, 32'h508, 32'h504, 32'h500};
        plan_rdata = {32'h0, 32'hCC, 32'hBB, 32'h12345678};
        build_model();
        applyStimulus();
        vectors++;
        if (obs_timeout || obs_addr.size() !== 2) begin
            miscompares++; $display("[TB] FAIL buserr_issued: got %0d expected 2", obs_addr.size());
        end
        vectors++;
        if ({bus.rsp_error, bus.rsp_misalign, bus.rsp_err_idx} !== 4'b1001) begin
            miscompares++; $display("[TB] FAIL buserr_status: got err=%b mis=%b idx=%0d expected 1/0/1",
                                    bus.rsp_error, bus.rsp_misalign, bus.rsp_err_idx);
        end
        vectors++;
        if (bus.rsp_rdata[31:0] !== 32'h12345678 || bus.rsp_rdata !== exp_rdata) begin
            miscompares++; $display("[TB] FAIL buserr_rdata: got %h expected %h", bus.rsp_rdata, exp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_misalign();
        clear_plan();
        r_wen = 0; r_count = 3; r_ben = 16'hFFFF; r_wdata = 0;
        r_addr = {32'h20C, 32'h202, 32'h204, 32'h200};
        plan_rdata = {4{$urandom}};
        build_model();
        applyStimulus();
        vectors++;
        if (obs_timeout || obs_addr.size() !== 2 || obs_cycle !== 8) begin
            miscompares++; $display("[TB] FAIL misalign_issued: got %0d accepts at cycle %0d expected 2 at 8", obs_addr.size(), obs_cycle);
        end
        vectors++;
        if ({bus.rsp_error, bus.rsp_misalign, bus.rsp_err_idx} !== 4'b1110 || bus.rsp_rdata !== exp_rdata) begin
            miscompares++; $display("[TB] FAIL misalign_status: got err=%b mis=%b idx=%0d rdata=%h expected 1/1/2 %h",
                                    bus.rsp_error, bus.rsp_misalign, bus.rsp_err_idx, bus.rsp_rdata, exp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_flush();
        bit seen;
        clear_plan();
        r_wen = 0; r_count = 0; r_ben = 16'hF; r_wdata = 0; r_addr = 128'h300;
        start_req();
        bus.mem_stall = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.mem_cen) seen = 1; else @(negedge g_clk);
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("[TB] FAIL flush_cen_seen: got no mem_cen expected one within 10 cycles");
        end
        bus.flush = 1;
        @(negedge g_clk);
        bus.flush = 0; bus.mem_stall = 0;
        vectors++;
        if ({bus.mem_cen, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
            miscompares++; $display("[TB] FAIL flush_issue: got cen=%b valid=%b ready=%b expected 0/0/1",
                                    bus.mem_cen, bus.rsp_valid, bus.req_ready);
        end
`ifdef COP_MEM_TRACE_EN
        vectors++;
        if (bus.trc_cen !== 4'h0) begin
            miscompares++; $display("[TB] FAIL flush_trace: got %h expected 0", bus.trc_cen);
        end
`endif
        // Flush during the response cycle: the accepted access completes, then nothing is returned
        start_req();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.mem_cen) seen = 1; else @(negedge g_clk);
        end
        @(negedge g_clk);
        bus.flush = 1; bus.mem_rdata = 32'hDEAD;
        @(negedge g_clk);
        bus.flush = 0;
        repeat (2) @(negedge g_clk);
        vectors++;
        if ({bus.mem_cen, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
            miscompares++; $display("[TB] FAIL flush_resp: got cen=%b valid=%b ready=%b expected 0/0/1",
                                    bus.mem_cen, bus.rsp_valid, bus.req_ready);
        end
        r_count = 1; r_addr = {64'h0, 32'h314, 32'h310}; plan_rdata = {64'h0, 32'h77, 32'h66};
        build_model();
        applyStimulus();
        vectors++;
        if (obs_timeout || bus.rsp_rdata !== exp_rdata || obs_addr.size() !== 2) begin
            miscompares++; $display("[TB] FAIL flush_next: got %h expected %h", bus.rsp_rdata, exp_rdata);
        end
`ifdef COP_MEM_TRACE_EN
        vectors++;
        if (bus.trc_cen !== 4'h3) begin
            miscompares++; $display("[TB] FAIL flush_next_trace: got %h expected 3", bus.trc_cen);
        end
`endif
        finish_rsp();
    endtask

    task automatic test_done_hold();
        clear_plan();
        r_wen = 0; r_count = 0; r_ben = 16'hF; r_wdata = 0; r_addr = 128'h600;
        plan_rdata = {4{$urandom}};
        build_model();
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_rdata !== exp_rdata || bus.rsp_error !== 1'b0) begin
                miscompares++; $display("[TB] FAIL done_hold[%0d]: got valid=%b ready=%b rdata=%h expected 1/0 %h",
                                        i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, exp_rdata);
            end
            @(negedge g_clk);
        end
        finish_rsp();
    endtask

    task automatic test_reset_in_resp();
        bit seen;
        clear_plan();
        r_wen = 0; r_count = 1; r_ben = 16'hFF; r_wdata = 0; r_addr = {64'h0, 32'h704, 32'h700};
        start_req();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.mem_cen) seen = 1; else @(negedge g_clk);
        end
        @(negedge g_clk);
        g_resetn = 0; bus.mem_rdata = 32'hFACE; bus.mem_error = 1;
        @(negedge g_clk);
        g_resetn = 1; bus.mem_error = 0;
        vectors++;
        if (!seen || bus.req_ready !== 1'b1 || {bus.mem_cen, bus.mem_addr, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_in_resp: got ready=%b cen=%b valid=%b rdata=%h expected 1/0/0/0",
                                    bus.req_ready, bus.mem_cen, bus.rsp_valid, bus.rsp_rdata);
        end
        repeat (3) @(negedge g_clk);
        vectors++;
        if (bus.mem_cen !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_stays_idle: got cen=%b valid=%b expected 0/0", bus.mem_cen, bus.rsp_valid);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            r_wen = 1'($urandom); r_count = 2'($urandom); r_ben = 16'($urandom);
            r_wdata = {$urandom, $urandom, $urandom, $urandom};
            plan_rdata = {$urandom, $urandom, $urandom, $urandom};
            plan_err = 0;
            for (int i = 0; i < 4; i++) begin
                r_addr[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
                plan_stall[i] = $urandom_range(0, 2);
                plan_err[i] = ($urandom_range(0, 7) == 0);
            end
            build_model();
            applyStimulus();
            vectors++;
            if (obs_timeout || obs_cycle !== exp_cycle || obs_cen_cycles !== exp_cen_cycles || obs_unstable !== 0) begin
                miscompares++; $display("[TB] FAIL rand%0d_timing: got cycle %0d cen %0d unstable %0d expected %0d/%0d/0",
                                        t, obs_cycle, obs_cen_cycles, obs_unstable, exp_cycle, exp_cen_cycles);
            end
            vectors++;
            if (obs_addr.size() !== exp_addr.size()) begin
                miscompares++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", t, obs_addr.size(), exp_addr.size());
            end
            for (int k = 0; k < obs_addr.size() && k < exp_addr.size(); k++) begin
                vectors++;
                if (obs_addr[k] !== exp_addr[k] || obs_wen[k] !== r_wen ||
                    obs_wdata[k] !== r_wdata[k*32 +: 32] || obs_ben[k] !== r_ben[k*4 +: 4]) begin
                    miscompares++; $display("[TB] FAIL rand%0d_lane%0d: got addr=%h wdata=%h ben=%h expected %h/%h/%h",
                                            t, k, obs_addr[k], obs_wdata[k], obs_ben[k], exp_addr[k], r_wdata[k*32 +: 32], r_ben[k*4 +: 4]);
                end
            end
            vectors++;
            if (bus.rsp_rdata !== exp_rdata || bus.rsp_error !== exp_error || bus.rsp_misalign !== exp_misalign ||
                bus.rsp_err_idx !== exp_idx) begin
                miscompares++; $display("[TB] FAIL rand%0d_rsp: got %h e=%b m=%b i=%0d expected %h e=%b m=%b i=%0d",
                                        t, bus.rsp_rdata, bus.rsp_error, bus.rsp_misalign, bus.rsp_err_idx,
                                        exp_rdata, exp_error, exp_misalign, exp_idx);
            end
`ifdef COP_MEM_TRACE_EN
            vectors++;
            if (bus.trc_cen !== exp_trc_cen || bus.trc_rdata !== exp_trc_rdata) begin
                miscompares++; $display("[TB] FAIL rand%0d_trace: got cen=%h rdata=%h expected %h/%h",
                                        t, bus.trc_cen, bus.trc_rdata, exp_trc_cen, exp_trc_rdata);
            end
`endif
            finish_rsp();
        end
    endtask

    task automatic checkOutput();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_load4();
        test_store_stall();
        test_bus_error();
        test_misalign();
        test_flush();
        test_done_hold();
        test_reset_in_resp();
        test_random();
        checkOutput();
        $finish;
    end
endmodule
